// File: rtl/reg_bus_pkg.sv
// Shared state encoding and constants for the register-bus sequencer.
package reg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        TURN = 3'd3,
        RESP = 3'd4
    } state_t;

    // Fill bit for the read data returned on an address error
    localparam bit ERR_RDATA_BIT = 1'b1;

    function automatic logic is_ticked_state(state_t s);
        return (s == WR) || (s == RD) || (s == TURN);
    endfunction

endpackage

// File: rtl/reg_bus_ctrl_decode.sv
// One-hot register select decoder; 'invert' produces active-low selects.
module reg_bus_decode #(
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3
) (
    input  logic [AddrBits-1:0] addr,
    input  logic                en,
    input  logic                invert,
    output logic [NrOfRegs-1:0] sel
);

    for (genvar i = 0; i < NrOfRegs; i++) begin : g_sel
        assign sel[i] = invert ^ (en && (addr == AddrBits'(i)));
    end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Tick-paced sequencer driving write enables and output disables of a tri-state
// register bank. Optional macro REG_BUS_ADDR_CHECK_EN adds out-of-range address errors.
module reg_bus_ctrl
    import reg_bus_pkg::*;
#(
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3,
    parameter int NrOfBits = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AddrBits-1:0] req_addr,
    input  logic [NrOfBits-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [NrOfBits-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [NrOfRegs-1:0] reg_we,
    output logic [NrOfRegs-1:0] reg_cs,
    output logic [NrOfBits-1:0] bus_d,
    input  logic [NrOfBits-1:0] bus_q
);

    state_t                state_q;
    logic [AddrBits-1:0]   addr_q;
    logic [NrOfBits-1:0]   wdata_q;
    logic [NrOfBits-1:0]   rdata_q;

`ifdef REG_BUS_ADDR_CHECK_EN
    localparam logic [AddrBits:0] NREGS_W = (AddrBits+1)'(NrOfRegs);
    logic err_q;
    logic in_range;
    assign in_range = ({1'b0, req_addr} < NREGS_W);
    assign rsp_err  = err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef REG_BUS_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
`ifdef REG_BUS_ADDR_CHECK_EN
                    // Bad address: answer straight away without touching the bus
                    if (!in_range) begin
                        err_q   <= 1'b1;
                        rdata_q <= {NrOfBits{ERR_RDATA_BIT}};
                        state_q <= RESP;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= req_write ? WR : RD;
                    end
`else
                    state_q <= req_write ? WR : RD;
`endif
                end
                WR:   if (Tick) state_q <= RESP;
                RD:   if (Tick) begin
                    rdata_q <= bus_q;
                    state_q <= TURN;
                end
                TURN: if (Tick) state_q <= RESP;
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign bus_d     = wdata_q;

    // Selects depend only on registered state, so reset kills them asynchronously
    reg_bus_decode #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_we_dec (
        .addr   (addr_q),
        .en     (is_ticked_state(state_q) && (state_q == WR)),
        .invert (1'b0),
        .sel    (reg_we)
    );

    reg_bus_decode #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_cs_dec (
        .addr   (addr_q),
        .en     (state_q == RD),
        .invert (1'b1),
        .sel    (reg_cs)
    );

endmodule
